// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if
//   Bundles the sequencer's control, pattern-write and tone-generator signals.
//   master: user controls / pattern writer (drives start, stop, loop, wr_*).
//   slave : melody_sequencer (drives note, en, busy, step, done, dbg_state).
//
//   Signal semantics (no valid/ready pairs on this block):
//     start, stop : single-cycle pulses sampled on the rising clk edge.
//     loop        : level, sampled only when a song reaches its end.
//     wr_en       : strobe; wr_addr/wr_data are written on the same edge,
//                   one entry per cycle, always accepted.
//     done        : one-cycle pulse; note/en/busy/step are plain levels.
//     dbg_state   : current FSM state (0=IDLE, 1=NOTE, 2=GAP).
interface melody_sequencer_if #(
    parameter int AW = 4
);
    logic          start;
    logic          stop;
    logic          loop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [2:0]    note;
    logic          en;
    logic          busy;
    logic [AW-1:0] step;
    logic          done;
    logic [1:0]    dbg_state;

    modport master (
        output start, stop, loop, wr_en, wr_addr, wr_data,
        input  note, en, busy, step, done, dbg_state
    );

    modport slave (
        input  start, stop, loop, wr_en, wr_addr, wr_data,
        output note, en, busy, step, done, dbg_state
    );
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Plays a programmable pattern of {note[2:0], dur[3:0]} entries and drives
//   the tone generator's note/en inputs. Each note lasts dur tempo ticks,
//   optionally followed by GAP_TICKS silent ticks. dur==0 marks end of song.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (also clears the pattern memory)
//   bus  : melody_sequencer_if.slave (controls, write port, generator outputs)
module melody_sequencer #(
    parameter int TICK_CLKS = 6250000,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int GAP_TICKS = 1
) (
    input  logic                clk,
    input  logic                rst,
    melody_sequencer_if.slave   bus
);
    localparam int            CW        = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CLKS - 1);
    localparam logic [15:0]   GAP_LAST  = (GAP_TICKS > 0) ? 16'(GAP_TICKS - 1) : 16'd0;
    localparam logic [AW-1:0] STEP_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    note_q, note_d;
    logic [3:0]    dur_q, dur_d;
    logic [AW-1:0] step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;     // clk cycles within the current tick
    logic [15:0]   tcnt_q, tcnt_d;   // ticks elapsed in the current NOTE/GAP
    logic          done_q, done_d;
    logic [6:0]    mem [DEPTH];

    logic [6:0]    entry0, entry_nx;
    logic [AW-1:0] step_inc;
    logic [15:0]   period_last;
    logic          tick_end, period_end, adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            dur_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            done_q  <= done_d;
            if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        // Memory reads see the pre-write contents, so a same-cycle write and
        // load of one address returns the old entry.
        entry0      = mem[0];
        step_inc    = step_q + AW'(1);
        entry_nx    = mem[step_inc];
        tick_end    = (cnt_q == TICK_LAST);
        period_last = (state_q == S_NOTE) ? ({12'd0, dur_q} - 16'd1) : GAP_LAST;
        period_end  = tick_end && (tcnt_q == period_last);

        state_d = state_q;
        note_d  = note_q;
        dur_d   = dur_q;
        step_d  = step_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        if (tick_end) begin
            cnt_d  = '0;
            tcnt_d = tcnt_q + 16'd1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tcnt_d = tcnt_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                tcnt_d = '0;
                if (bus.start) begin
                    if (entry0[3:0] != 4'd0) begin
                        state_d = S_NOTE;
                        note_d  = entry0[6:4];
                        dur_d   = entry0[3:0];
                        step_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_NOTE: begin
                if (period_end) begin
                    if (GAP_TICKS == 0) begin
                        adv = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                    end
                end
            end
            S_GAP: begin
                if (period_end) adv = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Load the next entry, wrap to entry 0 when looping, or end the song.
        if (adv) begin
            cnt_d  = '0;
            tcnt_d = '0;
            if ((step_q != STEP_LAST) && (entry_nx[3:0] != 4'd0)) begin
                state_d = S_NOTE;
                note_d  = entry_nx[6:4];
                dur_d   = entry_nx[3:0];
                step_d  = step_inc;
            end else if (bus.loop && (entry0[3:0] != 4'd0)) begin
                state_d = S_NOTE;
                note_d  = entry0[6:4];
                dur_d   = entry0[3:0];
                step_d  = '0;
            end else begin
                state_d = S_IDLE;
                note_d  = '0;
                step_d  = '0;
                done_d  = 1'b1;
            end
        end

        // stop overrides start and a coinciding song end (no done pulse).
        if (bus.stop) begin
            state_d = S_IDLE;
            note_d  = '0;
            step_d  = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            tcnt_d  = '0;
        end
    end

    assign bus.note      = note_q;
    assign bus.en        = (state_q == S_NOTE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.step      = step_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer
//   Directed bench for melody_sequencer with TICK_CLKS=4, GAP_TICKS=1, DEPTH=16.
//   The driver pushes the expected {note,en,busy,step,done} for each checked
//   cycle; the monitor pops and compares on the falling edge.
module tb_melody_sequencer;
    localparam int AW = 4;
    localparam int W  = 10;

    logic clk;
    logic rst;

    melody_sequencer_if #(.AW(AW)) sq_if ();

    melody_sequencer #(
        .TICK_CLKS (4),
        .DEPTH     (16),
        .AW        (AW),
        .GAP_TICKS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sq_if.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_name;

    function automatic logic [W-1:0] pk(input logic [2:0] n, input logic e, input logic b,
                                        input logic [3:0] s, input logic d);
        return {n, e, b, s, d};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {sq_if.note, sq_if.en, sq_if.busy, sq_if.step, sq_if.done};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s @%0t: got note=%0d en=%0b busy=%0b step=%0d done=%0b, expected note=%0d en=%0b busy=%0b step=%0d done=%0b",
                         mon_name, $time, mon_act[9:7], mon_act[6], mon_act[5], mon_act[4:1], mon_act[0],
                         mon_exp[9:7], mon_exp[6], mon_exp[5], mon_exp[4:1], mon_exp[0]);
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
        sq_if.start = 1'b0;
        sq_if.stop  = 1'b0;
        sq_if.wr_en = 1'b0;
    endtask

    task automatic push_exp(input string nm, input logic [W-1:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic expect_cycles(input string nm, input int n, input logic [W-1:0] v);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            push_exp(nm, v);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [2:0] n, input logic [3:0] d);
        next_cycle();
        sq_if.wr_en   = 1'b1;
        sq_if.wr_addr = a;
        sq_if.wr_data = {n, d};
    endtask

    // cycle 0 of a song: start is high, outputs still idle
    task automatic start_pulse(input string nm);
        next_cycle();
        sq_if.start = 1'b1;
        push_exp(nm, pk(3'd0, 1'b0, 1'b0, 4'd0, 1'b0));
    endtask

    // timeout guard
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got no end of sequence, expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        sq_if.start   = 1'b0;
        sq_if.stop    = 1'b0;
        sq_if.loop    = 1'b0;
        sq_if.wr_en   = 1'b0;
        sq_if.wr_addr = '0;
        sq_if.wr_data = '0;
        rst = 1'b1;

        // reset state
        next_cycle();
        next_cycle();
        push_exp("reset", pk(0, 0, 0, 0, 0));
        rst = 1'b0;
        expect_cycles("post_reset_idle", 2, pk(0, 0, 0, 0, 0));

        // basic song, with an ignored start while busy at cycle 4
        write_entry(4'd0, 3'd1, 4'd2);
        write_entry(4'd1, 3'd3, 4'd1);
        write_entry(4'd2, 3'd0, 4'd0);
        start_pulse("a_cycle0");
        expect_cycles("a_note1", 3, pk(1, 1, 1, 0, 0));
        next_cycle();
        sq_if.start = 1'b1;
        push_exp("a_note1_start_busy", pk(1, 1, 1, 0, 0));
        expect_cycles("a_note1", 4, pk(1, 1, 1, 0, 0));
        expect_cycles("a_gap1", 4, pk(1, 0, 1, 0, 0));
        expect_cycles("a_note3", 4, pk(3, 1, 1, 1, 0));
        expect_cycles("a_gap3", 4, pk(3, 0, 1, 1, 0));
        expect_cycles("a_done", 1, pk(0, 0, 0, 0, 1));
        expect_cycles("a_idle", 2, pk(0, 0, 0, 0, 0));

        // loop; entry 0 rewritten on the cycle it is reloaded (old data wins); stop
        sq_if.loop = 1'b1;
        start_pulse("l_cycle0");
        expect_cycles("l_note1", 8, pk(1, 1, 1, 0, 0));
        expect_cycles("l_gap1", 4, pk(1, 0, 1, 0, 0));
        expect_cycles("l_note3", 4, pk(3, 1, 1, 1, 0));
        expect_cycles("l_gap3", 3, pk(3, 0, 1, 1, 0));
        next_cycle();
        sq_if.wr_en   = 1'b1;
        sq_if.wr_addr = 4'd0;
        sq_if.wr_data = {3'd2, 4'd1};
        push_exp("l_gap3_write", pk(3, 0, 1, 1, 0));
        expect_cycles("l_loop_note1", 2, pk(1, 1, 1, 0, 0));
        next_cycle();
        sq_if.stop = 1'b1;
        push_exp("l_note1_stop", pk(1, 1, 1, 0, 0));
        expect_cycles("l_stopped", 2, pk(0, 0, 0, 0, 0));
        sq_if.loop = 1'b0;

        // stop coinciding with song end: no done
        start_pulse("s_cycle0");
        expect_cycles("s_note2", 4, pk(2, 1, 1, 0, 0));
        expect_cycles("s_gap2", 4, pk(2, 0, 1, 0, 0));
        expect_cycles("s_note3", 4, pk(3, 1, 1, 1, 0));
        expect_cycles("s_gap3", 3, pk(3, 0, 1, 1, 0));
        next_cycle();
        sq_if.stop = 1'b1;
        push_exp("s_gap3_stop", pk(3, 0, 1, 1, 0));
        expect_cycles("s_no_done", 3, pk(0, 0, 0, 0, 0));

        // start and stop together: stays idle
        next_cycle();
        sq_if.start = 1'b1;
        sq_if.stop  = 1'b1;
        push_exp("ss_cycle0", pk(0, 0, 0, 0, 0));
        expect_cycles("ss_idle", 3, pk(0, 0, 0, 0, 0));

        // rewrite entry 0 during its NOTE; next pass plays the new entry
        write_entry(4'd0, 3'd1, 4'd2);
        sq_if.loop = 1'b1;
        start_pulse("r_cycle0");
        expect_cycles("r_note1", 2, pk(1, 1, 1, 0, 0));
        next_cycle();
        sq_if.wr_en   = 1'b1;
        sq_if.wr_addr = 4'd0;
        sq_if.wr_data = {3'd7, 4'd1};
        push_exp("r_note1_write", pk(1, 1, 1, 0, 0));
        expect_cycles("r_note1", 5, pk(1, 1, 1, 0, 0));
        expect_cycles("r_gap1", 4, pk(1, 0, 1, 0, 0));
        expect_cycles("r_note3", 4, pk(3, 1, 1, 1, 0));
        expect_cycles("r_gap3", 4, pk(3, 0, 1, 1, 0));
        expect_cycles("r_note7", 4, pk(7, 1, 1, 0, 0));
        expect_cycles("r_gap7", 4, pk(7, 0, 1, 0, 0));
        expect_cycles("r_note3b", 1, pk(3, 1, 1, 1, 0));
        next_cycle();
        sq_if.stop = 1'b1;
        push_exp("r_note3b_stop", pk(3, 1, 1, 1, 0));
        expect_cycles("r_stopped", 2, pk(0, 0, 0, 0, 0));
        sq_if.loop = 1'b0;

        // full pattern: 16 entries, song ends after entry 15's gap
        for (int i = 0; i < 16; i++) write_entry(4'(i), 3'd5, 4'd1);
        start_pulse("f_cycle0");
        for (int k = 0; k < 16; k++) begin
            expect_cycles("f_note", 4, pk(5, 1, 1, 4'(k), 0));
            expect_cycles("f_gap", 4, pk(5, 0, 1, 4'(k), 0));
        end
        expect_cycles("f_done", 1, pk(0, 0, 0, 0, 1));
        expect_cycles("f_idle", 1, pk(0, 0, 0, 0, 0));

        // reset mid-NOTE clears outputs and pattern
        start_pulse("m_cycle0");
        expect_cycles("m_note5", 3, pk(5, 1, 1, 0, 0));
        rst = 1'b1;
        expect_cycles("m_reset", 1, pk(0, 0, 0, 0, 0));
        rst = 1'b0;
        expect_cycles("m_after_reset", 1, pk(0, 0, 0, 0, 0));
        start_pulse("e_cycle0");
        expect_cycles("e_done", 1, pk(0, 0, 0, 0, 1));
        expect_cycles("e_idle", 3, pk(0, 0, 0, 0, 0));

        next_cycle();
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
